irq_ctrl: RTL

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
// Priority interrupt controller: per-source gateway FSMs, config registers and a
// registered arbiter. Define IRQ_CTRL_EDGE_EN to build the edge-trigger register and edge latches.
module irq_ctrl #(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic              cfg_we_i,
  input  logic [7:0]        cfg_addr_i,
  input  logic [31:0]       cfg_wdata_i,
  output logic [31:0]       cfg_rdata_o,
  input  logic              claim_i,
  input  logic              complete_i,
  input  logic [4:0]        complete_id_i,
  output logic              irq_o,
  output logic [4:0]        irq_id_o,
  output logic [PRIO_W-1:0] irq_prio_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, PENDING = 2'd1, CLAIMED = 2'd2} gw_state_e;

  function automatic logic [31:0] src_mask();
    logic [31:0] m;
    m = 32'd0;
    for (int k = 1; k <= NUM_SRC; k++) m[k] = 1'b1;
    return m;
  endfunction

  localparam logic [31:0] SRC_MASK = src_mask();

  logic [NUM_SRC:1]  src_v;
  gw_state_e         gw_q [1:NUM_SRC];
  gw_state_e         gw_d [1:NUM_SRC];
  logic [31:0]       enable_q, enable_d;
  logic [PRIO_W-1:0] threshold_q, threshold_d;
  logic [PRIO_W-1:0] prio_q [1:NUM_SRC];
  logic [PRIO_W-1:0] prio_d [1:NUM_SRC];
  logic [31:0]       pending_s;
  logic              irq_q, irq_d;
  logic [4:0]        irq_id_q, irq_id_d;
  logic [PRIO_W-1:0] irq_prio_q, irq_prio_d;
`ifdef IRQ_CTRL_EDGE_EN
  logic [31:0]       trigger_q, trigger_d;
  logic [NUM_SRC:1]  prev_src_q;
  logic [NUM_SRC:1]  edge_latch_q, edge_latch_d;
`endif

  assign src_v = src_i;

  always_comb begin
    gw_d = gw_q;
    pending_s = 32'd0;
`ifdef IRQ_CTRL_EDGE_EN
    edge_latch_d = edge_latch_q;
`endif
    for (int k = 1; k <= NUM_SRC; k++) begin
      logic req;
      logic rise;
      pending_s[k] = (gw_q[k] == PENDING);
`ifdef IRQ_CTRL_EDGE_EN
      rise = src_v[k] & ~prev_src_q[k];
      req  = trigger_q[k] ? (rise | edge_latch_q[k]) : src_v[k];
      // An edge arriving while the gateway is busy is remembered once.
      if (trigger_q[k] && rise && gw_q[k] != IDLE) edge_latch_d[k] = 1'b1;
`else
      rise = 1'b0;
      req  = src_v[k] | rise;
`endif
      case (gw_q[k])
        IDLE: begin
          if (req) begin
            gw_d[k] = PENDING;
`ifdef IRQ_CTRL_EDGE_EN
            edge_latch_d[k] = 1'b0;
`endif
          end else begin
            gw_d[k] = IDLE;
          end
        end
        PENDING: gw_d[k] = (claim_i && irq_q && irq_id_q == 5'(k)) ? CLAIMED : PENDING;
        CLAIMED: gw_d[k] = (complete_i && complete_id_i == 5'(k)) ? IDLE : CLAIMED;
        default: gw_d[k] = IDLE;
      endcase
    end
  end

  // Strict '>' keeps the lowest ID on ties and stops priority 0 from ever winning.
  always_comb begin
    logic [PRIO_W-1:0] best;
    irq_d = 1'b0;
    irq_id_d = 5'd0;
    best = threshold_q;
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (gw_q[k] == PENDING && enable_q[k] && prio_q[k] > best) begin
        best = prio_q[k];
        irq_id_d = 5'(k);
        irq_d = 1'b1;
      end
    end
    irq_prio_d = irq_d ? best : {PRIO_W{1'b0}};
  end

  always_comb begin
    enable_d = enable_q;
    threshold_d = threshold_q;
    prio_d = prio_q;
`ifdef IRQ_CTRL_EDGE_EN
    trigger_d = trigger_q;
`endif
    if (cfg_we_i) begin
      case (cfg_addr_i)
        8'h00: enable_d = cfg_wdata_i & SRC_MASK;
        8'h04: threshold_d = cfg_wdata_i[PRIO_W-1:0];
`ifdef IRQ_CTRL_EDGE_EN
        8'h0C: trigger_d = cfg_wdata_i & SRC_MASK;
`endif
        default: begin
          for (int k = 1; k <= NUM_SRC; k++) begin
            if (cfg_addr_i == 8'(16 + 4 * (k - 1))) prio_d[k] = cfg_wdata_i[PRIO_W-1:0];
          end
        end
      endcase
    end
  end

  always_comb begin
    cfg_rdata_o = 32'd0;
    case (cfg_addr_i)
      8'h00: cfg_rdata_o = enable_q;
      8'h04: cfg_rdata_o = 32'(threshold_q);
      8'h08: cfg_rdata_o = pending_s;
`ifdef IRQ_CTRL_EDGE_EN
      8'h0C: cfg_rdata_o = trigger_q;
`endif
      default: begin
        for (int k = 1; k <= NUM_SRC; k++) begin
          if (cfg_addr_i == 8'(16 + 4 * (k - 1))) cfg_rdata_o = 32'(prio_q[k]);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 1; k <= NUM_SRC; k++) begin
        gw_q[k]   <= IDLE;
        prio_q[k] <= {PRIO_W{1'b0}};
      end
      enable_q    <= 32'd0;
      threshold_q <= {PRIO_W{1'b0}};
      irq_q       <= 1'b0;
      irq_id_q    <= 5'd0;
      irq_prio_q  <= {PRIO_W{1'b0}};
`ifdef IRQ_CTRL_EDGE_EN
      trigger_q    <= 32'd0;
      prev_src_q   <= {NUM_SRC{1'b0}};
      edge_latch_q <= {NUM_SRC{1'b0}};
`endif
    end else begin
      gw_q        <= gw_d;
      prio_q      <= prio_d;
      enable_q    <= enable_d;
      threshold_q <= threshold_d;
      irq_q       <= irq_d;
      irq_id_q    <= irq_id_d;
      irq_prio_q  <= irq_prio_d;
`ifdef IRQ_CTRL_EDGE_EN
      trigger_q    <= trigger_d;
      prev_src_q   <= src_v;
      edge_latch_q <= edge_latch_d;
`endif
    end
  end

  assign irq_o      = irq_q;
  assign irq_id_o   = irq_id_q;
  assign irq_prio_o = irq_prio_q;

endmodule
